svm_coef_loader: RTL

- Sequencer that loads the SVM coefficient RAM and bias of the HOG+SVM detector from a narrow coefficient stream.
- Assembles N_COEF coefficients per beat group into one RAM line and writes N_WORD lines through the RAM port (addr_a / write_en / i_data_a). Then loads the bias (bias / b_load).
- Holds the detection pipeline disabled (run_en low) until the full coefficient set is committed.
- Sits between the configuration bus and the hog_svm top.

---
 rtl/svm_coef_loader.sv | 111 +++++++++++
 1 files changed

// File: rtl/svm_coef_loader.sv
// svm_coef_loader: packs a narrow coefficient stream into SVM RAM lines, then loads the bias.
// run_en stays low from an accepted start until the whole coefficient set has been committed.
`default_nettype none

module svm_coef_loader #(
  parameter int COEF_W = 16,
  parameter int N_COEF = 105,
  parameter int N_WORD = 36,
  parameter int ADDR_W = 6,
  parameter int RAM_DW = COEF_W * N_COEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [COEF_W-1:0] s_data,
  output logic [ADDR_W-1:0] addr_a,
  output logic              write_en,
  output logic [RAM_DW-1:0] o_line,
  output logic [COEF_W-1:0] bias,
  output logic              b_load,
  output logic              busy,
  output logic              done,
  output logic              run_en
);

  localparam int CNT_W = $clog2(N_COEF);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_BIAS  = 3'd3;
  localparam logic [2:0] S_BLOAD = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state;
  logic [CNT_W-1:0]  coef_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic              hs;

  assign s_ready  = (state == S_FILL) || (state == S_BIAS);
  assign hs       = s_valid && s_ready;
  assign addr_a   = word_cnt;
  assign write_en = (state == S_WRITE);
  assign b_load   = (state == S_BLOAD);
  assign done     = (state == S_DONE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      coef_cnt <= '0;
      word_cnt <= '0;
      o_line   <= '0;
      bias     <= '0;
      run_en   <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      // Abort wins over handshakes; run_en was already cleared by the accepted start.
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FILL;
            coef_cnt <= '0;
            word_cnt <= '0;
            run_en   <= 1'b0;
          end
        end
        S_FILL: begin
          if (hs) begin
            for (int i = 0; i < N_COEF; i++) begin
              if (coef_cnt == CNT_W'(i)) o_line[i*COEF_W +: COEF_W] <= s_data;
            end
            if (coef_cnt == CNT_W'(N_COEF - 1)) begin
              coef_cnt <= '0;
              state    <= S_WRITE;
            end else begin
              coef_cnt <= coef_cnt + CNT_W'(1);
            end
          end
        end
        S_WRITE: begin
          if (word_cnt == ADDR_W'(N_WORD - 1)) begin
            state <= S_BIAS;
          end else begin
            word_cnt <= word_cnt + ADDR_W'(1);
            state    <= S_FILL;
          end
        end
        S_BIAS: begin
          if (hs) begin
            bias  <= s_data;
            state <= S_BLOAD;
          end
        end
        S_BLOAD: state <= S_DONE;
        S_DONE: begin
          state  <= S_IDLE;
          run_en <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
